// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake and a two-entry skid
// buffer. The main register drives mem_payload. The skid register absorbs the
// one word that is already in flight when the memory stage back-pressures.
// Both registers hold NOP_VALUE whenever they carry no valid entry, so a stale
// write enable can never reach the memory stage. A saturating counter records
// the cycles in which the memory stage stalls a valid entry.
module exe_mem_skid_reg #(
    parameter int                   PAYLOAD_W = 144,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = {PAYLOAD_W{1'b0}},
    parameter int                   CNT_W     = 16
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic                 flush,
    input  logic                 exe_valid,
    output logic                 exe_ready,
    input  logic [PAYLOAD_W-1:0] exe_payload,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [PAYLOAD_W-1:0] mem_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    // The state encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   exe_ready_q, exe_ready_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [CNT_W-1:0]       stall_q, stall_d;
    logic                   accept_s;
    logic                   pop_s;
    logic                   stall_s;

    // Handshake qualifiers. Both use only flop outputs on the local side.
    always_comb begin
        accept_s = exe_valid & exe_ready_q;
        pop_s    = mem_valid_q & mem_ready;
        stall_s  = mem_valid_q & ~mem_ready;
    end

    // Next-state and datapath selection. A flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A simultaneous pop has already been sampled downstream.
            // A simultaneous accept is dropped.
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = exe_payload;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_d  = exe_payload;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                        skid_d  = exe_payload;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // exe_ready is low here, so exe_valid is never accepted.
                    if (pop_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
        exe_ready_d = (state_d != ST_FULL);
        mem_valid_d = (state_d != ST_EMPTY);
    end

    // Saturating stall counter. Only reset clears it; flush does not.
    always_comb begin
        stall_d = stall_q;
        if (stall_s && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // State, payload and status registers with synchronous reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            exe_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            stall_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            exe_ready_q <= exe_ready_d;
            mem_valid_q <= mem_valid_d;
            stall_q     <= stall_d;
        end
    end

    // All outputs come straight from flops.
    always_comb begin
        exe_ready   = exe_ready_q;
        mem_valid   = mem_valid_q;
        mem_payload = main_q;
        occupancy   = state_q;
        stall_cnt   = stall_q;
    end

endmodule
